// File: rtl/seven_seg_games_pkg.sv
// Shared definitions for the 7-segment game sources: display codes, game state
// enum and the LFSR seed/taps used by the reaction and dice games.
package seven_seg_games_pkg;

    localparam logic [3:0] CODE_GO    = 4'd10;
    localparam logic [3:0] CODE_FALSE = 4'd11;
    localparam logic [3:0] CODE_BLANK = 4'd12;
    localparam logic [3:0] CODE_WAIT  = 4'd13;
    localparam logic [3:0] DIGIT_MAX  = 4'd9;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Taps 8,6,5,4 expressed as bit positions 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        GO,
        RESULT,
        FALSE
    } state_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/reaction_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4); non-zero seed keeps it
// out of the all-zero lock-up state.
module reaction_lfsr8
    import seven_seg_games_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= LFSR_SEED;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/game_reaction.sv
// Reaction-time game: arm, wait a pseudo-random delay, hit on GO; shows the
// reaction digit or a false-start code. Optional best score: GAME_REACTION_BEST_EN.
module game_reaction
    import seven_seg_games_pkg::*;
#(
    parameter int TICK_DIV         = 10000,
    parameter int MIN_DELAY_TICKS  = 50,
    parameter int DELAY_STEP_TICKS = 10,
    parameter int BIN_TICKS        = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_btn,
    input  logic       hit_btn,
    output logic [3:0] value,
    output logic       new_best,
    output logic       busy
);

    localparam int PRESC_W = $clog2(TICK_DIV) + 1;
    localparam int DELAY_W = $clog2(MIN_DELAY_TICKS + 15 * DELAY_STEP_TICKS + 1);
    localparam int BIN_W   = $clog2(BIN_TICKS) + 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [BIN_W-1:0]   BIN_LAST   = BIN_W'(BIN_TICKS - 1);

    state_t               state;
    state_t               state_next;
    logic [PRESC_W-1:0]   presc;
    logic [DELAY_W-1:0]   delay;
    logic [DELAY_W-1:0]   delay_load;
    logic [BIN_W-1:0]     bin;
    logic [3:0]           digit;
    logic [3:0]           value_next;
    logic                 busy_next;
    logic                 tick;
    logic                 enter_timed;
    logic [7:0]           lfsr_q;
    logic [3:0]           lfsr_unused;

    reaction_lfsr8 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (lfsr_q)
    );

    assign lfsr_unused = lfsr_q[7:4];
    assign tick        = (presc == PRESC_LAST);
    assign delay_load  = DELAY_W'(MIN_DELAY_TICKS)
                       + DELAY_W'(lfsr_q[3:0]) * DELAY_W'(DELAY_STEP_TICKS);
    assign enter_timed = (state_next != state) && ((state_next == ARMED) || (state_next == GO));

    // A hit always beats start or a coinciding tick; RESULT keeps its digit.
    always_comb begin
        state_next = state;
        value_next = value;
        case (state)
            IDLE: begin
                if (start_btn) state_next = ARMED;
            end
            ARMED: begin
                if (hit_btn) begin
                    state_next = FALSE;
                end else if (tick && (delay == DELAY_W'(1))) begin
                    state_next = GO;
                end
            end
            GO: begin
                if (hit_btn) begin
                    state_next = RESULT;
                    value_next = digit;
                end else if (tick && (bin == BIN_LAST) && (digit == DIGIT_MAX)) begin
                    state_next = RESULT;
                    value_next = DIGIT_MAX;
                end
            end
            RESULT, FALSE: begin
                if (start_btn) state_next = ARMED;
            end
            default: state_next = IDLE;
        endcase
        case (state_next)
            IDLE:    value_next = CODE_BLANK;
            ARMED:   value_next = CODE_WAIT;
            GO:      value_next = CODE_GO;
            FALSE:   value_next = CODE_FALSE;
            default: ;
        endcase
        busy_next = (state_next == ARMED) || (state_next == GO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            value <= CODE_BLANK;
            busy  <= 1'b0;
            presc <= '0;
            delay <= '0;
            bin   <= '0;
            digit <= '0;
        end else begin
            state <= state_next;
            value <= value_next;
            busy  <= busy_next;
            if (enter_timed || tick) begin
                presc <= '0;
            end else begin
                presc <= presc + PRESC_W'(1);
            end
            if ((state != ARMED) && (state_next == ARMED)) begin
                delay <= delay_load;
            end else if ((state == ARMED) && tick) begin
                delay <= delay - DELAY_W'(1);
            end
            // Reaction digit: one step every BIN_TICKS ticks, saturating at 9.
            if ((state != GO) && (state_next == GO)) begin
                bin   <= '0;
                digit <= '0;
            end else if ((state == GO) && tick) begin
                if (bin == BIN_LAST) begin
                    bin <= '0;
                    if (digit != DIGIT_MAX) digit <= digit + 4'd1;
                end else begin
                    bin <= bin + BIN_W'(1);
                end
            end
        end
    end

`ifdef GAME_REACTION_BEST_EN
    logic [3:0] best;
    logic       take_best;

    assign take_best = (state == GO) && hit_btn && (digit < best);

    // Only a real hit can improve the best; new_best lasts for the RESULT it earned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best     <= DIGIT_MAX;
            new_best <= 1'b0;
        end else if (take_best) begin
            best     <= digit;
            new_best <= 1'b1;
        end else if (state_next != RESULT) begin
            new_best <= 1'b0;
        end
    end
`else
    assign new_best = 1'b0;
`endif

endmodule

// File: tb/tb_game_reaction.sv
// Self-checking bench for game_reaction: timestamp-based behavioural model plus
// directed rounds (normal, false start, timeout, async reset, re-start in ARMED).
module tb_game_reaction;

    localparam int TICK_DIV = 4;
    localparam int MIN_D    = 2;
    localparam int STEP_D   = 1;
    localparam int BIN_T    = 2;
    localparam int GO_LIMIT = TICK_DIV * BIN_T * 10;

    localparam int P_IDLE   = 0;
    localparam int P_ARMED  = 1;
    localparam int P_GO     = 2;
    localparam int P_RESULT = 3;
    localparam int P_FALSE  = 4;

    logic       clk;
    logic       rst_n;
    logic       start_btn;
    logic       hit_btn;
    logic [3:0] value;
    logic       new_best;
    logic       busy;

    int total = 0;
    int bad   = 0;

    int         m_phase;
    int         m_k;
    int         m_armed_len;
    int         m_best;
    logic [7:0] m_lfsr;
    logic [3:0] exp_value;
    logic       exp_busy;
    logic       exp_new_best;

    game_reaction #(
        .TICK_DIV         (TICK_DIV),
        .MIN_DELAY_TICKS  (MIN_D),
        .DELAY_STEP_TICKS (STEP_D),
        .BIN_TICKS        (BIN_T)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_btn (start_btn),
        .hit_btn   (hit_btn),
        .value     (value),
        .new_best  (new_best),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one-cycle pulses; called and returns at posedge+1.
    task automatic applyStimulus(input logic s, input logic h);
        start_btn = s;
        hit_btn   = h;
        @(posedge clk);
        #1;
        start_btn = 1'b0;
        hit_btn   = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_for_go(output int cnt);
        cnt = 0;
        while ((value !== 4'd10) && (cnt < 400)) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        if (cnt >= 400) checkOutput("go_timeout", 32'(value), 32'd10);
    endtask

    function automatic int go_digit(input int k);
        return (k / TICK_DIV) / BIN_T;
    endfunction

    // Model: phase plus cycles spent in it; times derived from the tick arithmetic.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr       <= 8'hA5;
            m_phase      <= P_IDLE;
            m_k          <= 0;
            m_armed_len  <= 0;
            m_best       <= 9;
            exp_value    <= 4'd12;
            exp_busy     <= 1'b0;
            exp_new_best <= 1'b0;
        end else begin
            m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
            case (m_phase)
                P_IDLE, P_RESULT, P_FALSE: begin
                    if (start_btn) begin
                        m_phase      <= P_ARMED;
                        m_k          <= 0;
                        m_armed_len  <= TICK_DIV * (MIN_D + int'(m_lfsr[3:0]) * STEP_D);
                        exp_value    <= 4'd13;
                        exp_busy     <= 1'b1;
                        exp_new_best <= 1'b0;
                    end
                end
                P_ARMED: begin
                    if (hit_btn) begin
                        m_phase   <= P_FALSE;
                        exp_value <= 4'd11;
                        exp_busy  <= 1'b0;
                    end else if (m_k == m_armed_len - 1) begin
                        m_phase   <= P_GO;
                        m_k       <= 0;
                        exp_value <= 4'd10;
                    end else begin
                        m_k <= m_k + 1;
                    end
                end
                P_GO: begin
                    if (hit_btn) begin
                        m_phase   <= P_RESULT;
                        exp_value <= 4'(go_digit(m_k));
                        exp_busy  <= 1'b0;
`ifdef GAME_REACTION_BEST_EN
                        if (go_digit(m_k) < m_best) begin
                            m_best       <= go_digit(m_k);
                            exp_new_best <= 1'b1;
                        end
`endif
                    end else if (m_k == GO_LIMIT - 1) begin
                        m_phase   <= P_RESULT;
                        exp_value <= 4'd9;
                        exp_busy  <= 1'b0;
                    end else begin
                        m_k <= m_k + 1;
                    end
                end
                default: m_phase <= P_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        checkOutput("cyc_value", 32'(value), 32'(exp_value));
        checkOutput("cyc_busy", 32'(busy), 32'(exp_busy));
        checkOutput("cyc_new_best", 32'(new_best), 32'(exp_new_best));
    end

    initial begin
        int cnt;
        int len;
        logic nb_exp;
        rst_n     = 1'b1;
        start_btn = 1'b0;
        hit_btn   = 1'b0;
        #1 rst_n = 1'b0;
        #21 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("lfsr_model_pin", 32'(m_lfsr), 32'h2A);

        wait_cycles(20);
        checkOutput("idle_value", 32'(value), 32'd12);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("idle_hit_ignored", 32'(value), 32'd12);

        // Round 1: hit after 5 ticks -> digit 2, first best.
        applyStimulus(1'b1, 1'b0);
        checkOutput("armed_value", 32'(value), 32'd13);
        checkOutput("armed_busy", 32'(busy), 32'd1);
        len = m_armed_len;
        wait_for_go(cnt);
        checkOutput("armed_length", 32'(cnt), 32'(len));
        wait_cycles(20);
        applyStimulus(1'b0, 1'b1);
        checkOutput("round1_value", 32'(value), 32'd2);
        checkOutput("round1_busy", 32'(busy), 32'd0);
`ifdef GAME_REACTION_BEST_EN
        nb_exp = 1'b1;
`else
        nb_exp = 1'b0;
`endif
        checkOutput("round1_new_best", 32'(new_best), 32'(nb_exp));

        // Round 2: digit 3 is not an improvement.
        applyStimulus(1'b1, 1'b0);
        wait_for_go(cnt);
        wait_cycles(26);
        applyStimulus(1'b0, 1'b1);
        checkOutput("round2_value", 32'(value), 32'd3);
        checkOutput("round2_new_best", 32'(new_best), 32'd0);

        // False starts: early hit, then hit on the final armed tick.
        applyStimulus(1'b1, 1'b0);
        wait_cycles(2);
        applyStimulus(1'b0, 1'b1);
        checkOutput("false_early", 32'(value), 32'd11);
        applyStimulus(1'b1, 1'b0);
        len = m_armed_len;
        wait_cycles(len - 1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("false_last_tick", 32'(value), 32'd11);
        checkOutput("false_busy", 32'(busy), 32'd0);

        // Timeout after 20 ticks in GO.
        applyStimulus(1'b1, 1'b0);
        checkOutput("rearm_value", 32'(value), 32'd13);
        wait_for_go(cnt);
        wait_cycles(GO_LIMIT - 1);
        checkOutput("timeout_not_yet", 32'(value), 32'd10);
        wait_cycles(1);
        checkOutput("timeout_value", 32'(value), 32'd9);
        checkOutput("timeout_new_best", 32'(new_best), 32'd0);

        // Best must still be 2 after the timeout: digit 1 improves it.
        applyStimulus(1'b1, 1'b0);
        wait_for_go(cnt);
        wait_cycles(10);
        applyStimulus(1'b0, 1'b1);
        checkOutput("round3_value", 32'(value), 32'd1);
        checkOutput("round3_new_best", 32'(new_best), 32'(nb_exp));

        // Asynchronous reset in the middle of GO.
        applyStimulus(1'b1, 1'b0);
        wait_for_go(cnt);
        wait_cycles(5);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_value", 32'(value), 32'd12);
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Start during ARMED must not reload the delay.
        applyStimulus(1'b1, 1'b0);
        len = m_armed_len;
        wait_cycles(3);
        applyStimulus(1'b1, 1'b0);
        wait_for_go(cnt);
        checkOutput("restart_ignored_len", 32'(cnt + 4), 32'(len));
        wait_cycles(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
